// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: PC select, req/ready fetch, stall/flush.
// Define FETCH_DEBUG_EN to add the dbg_sel/disdata observation port.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        pcsrcD,
    input  logic        jumpD,
    input  logic        jalD,
    input  logic [31:0] pcbranchD,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instrD,
    output logic [5:0]  opD,
    output logic [5:0]  funcD,
    output logic [31:0] pcplus4D,
    output logic        validD,
    output logic        fetch_busy
`ifdef FETCH_DEBUG_EN
    ,
    input  logic [1:0]  dbg_sel,
    output logic [31:0] disdata
`endif
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} fetchState_t;

    fetchState_t state, stateNext;
    logic [31:0] pcF, pcPlus4F, pcNext, jumpTarget, redirectTarget;
    logic [31:0] pendPc, holdBuf, deliverWord;
    logic        pendValid, redirect;
    logic        deliver, loadPend, clearPend, captureHold;

    assign pcPlus4F       = pcF + 32'd4;
    assign jumpTarget     = {pcplus4D[31:28], instrD[25:0], 2'b00};
    assign redirect       = validD & (jumpD | jalD | pcsrcD);
    assign redirectTarget = (jumpD | jalD) ? jumpTarget : pcbranchD;
    assign pcNext         = redirect ? redirectTarget : pcPlus4F;

    assign imem_addr  = pcF;
    assign imem_req   = (state == RUN) & ~reset;
    assign fetch_busy = (state == RUN) & ~imem_ready;
    assign opD        = instrD[31:26];
    assign funcD      = instrD[5:0];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        stateNext   = state;
        deliver     = 1'b0;
        deliverWord = imem_rdata;
        loadPend    = 1'b0;
        clearPend   = 1'b0;
        captureHold = 1'b0;
        case (state)
            RUN: begin
                if (imem_ready) begin
                    // A redirect that arrived mid-wait turns the returning word into garbage.
                    if (pendValid) begin
                        clearPend = 1'b1;
                    end else if (!stallF) begin
                        deliver = 1'b1;
                    end else begin
                        captureHold = 1'b1;
                        stateNext   = HOLD;
                    end
                end else if (redirect && !stallF) begin
                    loadPend = 1'b1;
                end
            end
            HOLD: begin
                if (!stallF) begin
                    deliver     = 1'b1;
                    deliverWord = holdBuf;
                    stateNext   = RUN;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (reset) begin
            state     <= RUN;
            pcF       <= RESET_PC;
            pendValid <= 1'b0;
        end else begin
            state <= stateNext;
            if (clearPend) begin
                pcF       <= pendPc;
                pendValid <= 1'b0;
            end else if (deliver) begin
                pcF <= pcNext;
            end
            if (loadPend) begin
                pendValid <= 1'b1;
            end
        end
    end

    // NOTE: pendPc and holdBuf are only read while their qualifying flag/state is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (loadPend) begin
            pendPc <= redirectTarget;
        end
        if (captureHold) begin
            holdBuf <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instrD   <= 32'h0;
            pcplus4D <= 32'h0;
            validD   <= 1'b0;
        end else if (!stallD) begin
            if (flushD || !deliver) begin
                instrD <= 32'h0;
                validD <= 1'b0;
            end else begin
                instrD   <= deliverWord;
                pcplus4D <= pcPlus4F;
                validD   <= 1'b1;
            end
        end
    end

`ifdef FETCH_DEBUG_EN
    always_comb begin
        case (dbg_sel)
            2'b00:   disdata = pcF;
            2'b01:   disdata = instrD;
            2'b10:   disdata = pcplus4D;
            default: disdata = {28'b0, state == HOLD, pendValid, validD, fetch_busy};
        endcase
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard of expected IF/ID deliveries plus point checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stallF, stallD, flushD, pcsrcD, jumpD, jalD;
    logic [31:0] pcbranchD, imem_addr, imem_rdata, instrD, pcplus4D;
    logic        imem_req, imem_ready, validD, fetch_busy;
    logic [5:0]  opD, funcD;
    logic        memReady;
    logic [31:0] dataXor;
    logic        wasStalled = 1'b0;
    int          checks = 0;
    int          errors = 0;
`ifdef FETCH_DEBUG_EN
    logic [1:0]  dbg_sel = 2'b00;
    logic [31:0] disdata;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } expEntry_t;
    expEntry_t expQ[$];

    always #5 clk = ~clk;

    // Memory returns its address as data, except one jump word at 0x8000_000C.
    assign imem_ready = memReady;
    assign imem_rdata = ((imem_addr == 32'h8000_000C) ? 32'h0800_0040 : imem_addr) ^ dataXor;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .pcsrcD(pcsrcD), .jumpD(jumpD), .jalD(jalD), .pcbranchD(pcbranchD),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .instrD(instrD), .opD(opD), .funcD(funcD),
        .pcplus4D(pcplus4D), .validD(validD), .fetch_busy(fetch_busy)
`ifdef FETCH_DEBUG_EN
        , .dbg_sel(dbg_sel), .disdata(disdata)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
        expQ.push_back('{instr: instr, pc4: pc4});
    endtask

    always @(posedge clk) wasStalled <= stallD;

    // A new delivery is a valid IF/ID word that was not merely held by stallD.
    always @(negedge clk) begin
        if (!reset && validD && !wasStalled) begin
            checks++;
            assert (expQ.size() != 0) else begin
                errors++;
                $error("FAIL unexpectedDelivery: observed instrD=%h expected none", instrD);
            end
            if (expQ.size() != 0) begin
                expEntry_t e;
                e = expQ.pop_front();
                check("sbInstrD", instrD, e.instr);
                check("sbPcplus4D", pcplus4D, e.pc4);
            end
        end
    end

    initial begin
        reset = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
        pcsrcD = 1'b0; jumpD = 1'b0; jalD = 1'b0; pcbranchD = 32'h0;
        memReady = 1'b1; dataXor = 32'h0;

        @(negedge clk);
        @(negedge clk);
        check("rstReq", {31'b0, imem_req}, 32'h0);
        check("rstAddr", imem_addr, 32'h0);
        check("rstInstrD", instrD, 32'h0);
        check("rstPcplus4D", pcplus4D, 32'h0);
        check("rstValidD", {31'b0, validD}, 32'h0);
        check("rstOpFunc", {20'b0, opD, funcD}, 32'h0);
        reset = 1'b0;
        push(32'h0, 32'h4); push(32'h4, 32'h8); push(32'h8, 32'hC); push(32'hC, 32'h10);

        // Zero-wait streaming
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("seqAddr", imem_addr, 32'(4 * i));
            check("seqValidD", {31'b0, validD}, 32'h1);
        end

        // Three wait states at 0x10
        memReady = 1'b0;
        #1;
        check("waitBusy0", {31'b0, fetch_busy}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("waitBusy", {31'b0, fetch_busy}, 32'h1);
            check("waitAddr", imem_addr, 32'h10);
            check("waitBubble", {31'b0, validD}, 32'h0);
        end
        @(negedge clk);
        check("waitAddrLast", imem_addr, 32'h10);
        memReady = 1'b1;
        #1;
        check("waitBusyDone", {31'b0, fetch_busy}, 32'h0);
        push(32'h10, 32'h14);

        // Taken branch with flush
        @(negedge clk);
        check("brValidBefore", {31'b0, validD}, 32'h1);
        pcsrcD = 1'b1; pcbranchD = 32'h100; flushD = 1'b1;
        @(negedge clk);
        check("brAddr", imem_addr, 32'h100);
        check("brFlush", {31'b0, validD}, 32'h0);
        pcsrcD = 1'b0; flushD = 1'b0;
        push(32'h100, 32'h104);

        // Branch to the jump word, then take the jump
        @(negedge clk);
        pcsrcD = 1'b1; pcbranchD = 32'h8000_000C; flushD = 1'b1;
        @(negedge clk);
        check("br2Addr", imem_addr, 32'h8000_000C);
        pcsrcD = 1'b0; flushD = 1'b0;
        push(32'h0800_0040, 32'h8000_0010);
        @(negedge clk);
        check("jOpD", {26'b0, opD}, 32'h2);
        check("jFuncD", {26'b0, funcD}, 32'h0);
        jumpD = 1'b1; flushD = 1'b1;
        @(negedge clk);
        check("jAddr", imem_addr, 32'h8000_0100);
        check("jFlush", {31'b0, validD}, 32'h0);
        jumpD = 1'b0; flushD = 1'b0;
        push(32'h8000_0100, 32'h8000_0104);

        // PC wrap at the top of the address space
        @(negedge clk);
        pcsrcD = 1'b1; pcbranchD = 32'hFFFF_FFFC; flushD = 1'b1;
        @(negedge clk);
        check("wrapTopAddr", imem_addr, 32'hFFFF_FFFC);
        pcsrcD = 1'b0; flushD = 1'b0;
        push(32'hFFFF_FFFC, 32'h0);
        @(negedge clk);
        check("wrapAddr", imem_addr, 32'h0);
        push(32'h0, 32'h4);

        // stallF+stallD while ready -> HOLD; simultaneous flushD must lose to stallD
        @(negedge clk);
        check("preHoldAddr", imem_addr, 32'h4);
        stallF = 1'b1; stallD = 1'b1;
        @(negedge clk);
        check("holdReq", {31'b0, imem_req}, 32'h0);
        check("holdBusy", {31'b0, fetch_busy}, 32'h0);
        check("holdInstrD", instrD, 32'h0);
        check("holdPcplus4D", pcplus4D, 32'h4);
        dataXor = 32'hDEAD_0000; flushD = 1'b1;
        @(negedge clk);
        check("stallBeatsFlush", {31'b0, validD}, 32'h1);
        check("holdReq2", {31'b0, imem_req}, 32'h0);
        stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
        push(32'h4, 32'h8);
        @(negedge clk);
        dataXor = 32'h0;
        check("releaseReq", {31'b0, imem_req}, 32'h1);
        check("releaseAddr", imem_addr, 32'h8);
        push(32'h8, 32'hC);

        // Redirect to 0x200 while the fetch at 0xC is waiting
        @(negedge clk);
        check("preRedirAddr", imem_addr, 32'hC);
        memReady = 1'b0; pcsrcD = 1'b1; pcbranchD = 32'h200;
        @(negedge clk);
        pcsrcD = 1'b0;
        check("redirAddrStable", imem_addr, 32'hC);
        check("redirBusy", {31'b0, fetch_busy}, 32'h1);
        check("redirBubble", {31'b0, validD}, 32'h0);
        @(negedge clk);
        memReady = 1'b1;
        @(negedge clk);
        check("redirDiscard", {31'b0, validD}, 32'h0);
        check("redirAddr", imem_addr, 32'h200);
        push(32'h200, 32'h204);

        // Reset during a wait restarts at RESET_PC
        @(negedge clk);
        memReady = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstWaitReq", {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        check("rstWaitAddr", imem_addr, 32'h0);
        check("rstWaitValid", {31'b0, validD}, 32'h0);
        reset = 1'b0; memReady = 1'b1;
        push(32'h0, 32'h4);
        @(negedge clk);
        check("restartAddr", imem_addr, 32'h4);
        stallF = 1'b1; stallD = 1'b1;
        @(negedge clk);
        check("endReq", {31'b0, imem_req}, 32'h0);
`ifdef FETCH_DEBUG_EN
        dbg_sel = 2'b00;
        #1;
        check("dbgPc", disdata, 32'h4);
        dbg_sel = 2'b11;
        #1;
        check("dbgStatus", disdata, 32'hA);
`endif
        check("sbDrained", 32'(expQ.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipelined MIPS core, sitting directly upstream of the control unit. It owns the PC and selects the next PC from sequential, branch and jump/jal sources. It fetches over a req/ready instruction-memory handshake and presents `instrD`, `opD`, `funcD` and `pcplus4D` to decode. It honours the hazard unit's stall/flush controls and absorbs memory wait states.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stallF`  in  1  hold PC / fetch (hazard unit).
- `stallD`  in  1  hold IF/ID register.
- `flushD`  in  1  load bubble into IF/ID.
- `pcsrcD`  in  1  taken branch in decode.
- `jumpD`  in  1  `j` in decode.
- `jalD`  in  1  `jal` in decode.
- `pcbranchD`  in  32  branch target from decode.
- `imem_addr`  out  32  fetch address (= pcF).
- `imem_req`  out  1  fetch request.
- `imem_rdata`  in  32  instruction word.
- `imem_ready`  in  1  data valid / request accepted this cycle.
- `instrD`  out  32  decode-stage instruction.
- `opD`  out  6  `instrD[31:26]`.
- `funcD`  out  6  `instrD[5:0]`.
- `pcplus4D`  out  32  PC+4 of `instrD`.
- `validD`  out  1  `instrD` is a real instruction (0 = bubble).
- `fetch_busy`  out  1  fetch waiting on memory; hazard unit ORs this into stallF/stallD.

## Operation
- Next PC priority: `jumpD|jalD` -> `{pcplus4D[31:28], instrD[25:0], 2'b00}`; else `pcsrcD` -> `pcbranchD`; else `pcF+4`. Redirect only when `validD=1`.
- FSM states: RUN, HOLD.
  - RUN: `imem_req=1`, `imem_addr=pcF`. When `imem_ready`:
    - If `!stallF`: update pcF, deliver the word to IF/ID, stay in RUN.
    - If `stallF`: capture the word into the hold buffer, go to HOLD.
  - HOLD: `imem_req=0`. When `!stallF`: deliver the buffer, update pcF, go to RUN.
- Handshake: `imem_addr` stays stable while `imem_req=1` until `imem_ready`; requests are never aborted.
- Redirect during a wait (RUN, `!imem_ready`, redirect selected, `!stallF`):
  - Latch `pend_valid=1`, `pend_pc=target`.
  - On the returning `imem_ready`, discard the data, set `pcF<=pend_pc`, clear `pend_valid`, and load a bubble into IF/ID.
- IF/ID update, in priority order:
  - `stallD` -> hold.
  - `flushD` -> bubble.
  - Word delivered -> `instrD=word`, `pcplus4D=pcF+4`, `validD=1`.
  - Otherwise -> bubble.
- Bubble = `instrD=0` (sll nop), `validD=0`, `pcplus4D` unchanged.
- `fetch_busy = (state==RUN) & !imem_ready`.
- All PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: pcF=`RESET_PC`, state RUN, `pend_valid=0`, `instrD=0`, `opD=0`, `funcD=0`, `pcplus4D=0`, `validD=0`.
- While `reset=1`, `imem_req=0`.
- Zero-wait memory (ready in the request cycle): one instruction per cycle; `instrD` is valid one edge after `imem_ready`.
- Redirect seen in decode in cycle n: pcF = target at edge n; the wrong-path fetch is removed by `flushD` (no delay slot).
- Simultaneous `stallD` and `flushD`: stall wins.
- Reset mid-wait: the outstanding request is dropped, the FSM returns to RUN, and fetch restarts at `RESET_PC`.

## Configuration
- `FETCH_DEBUG_EN` defined:
  - Adds input `dbg_sel[1:0]` and output `disdata[31:0]`, combinational.
  - Select 00 = pcF; 01 = `instrD`; 10 = `pcplus4D`; 11 = `{28'b0, state, pend_valid, validD, fetch_busy}`.
- Undefined: these ports and that logic are absent; all other behaviour is identical.

## Test plan
- Reset, zero-wait memory returning addr as data -> `instrD` = 0,4,8,... on consecutive cycles; `validD=1` from the second edge.
- `imem_ready` low for 3 cycles at pcF=0x10 -> `fetch_busy=1` for 3 cycles, `imem_addr` stable at 0x10, bubbles in D, then `instrD=word@0x10`.
- `pcsrcD=1`, `pcbranchD=0x100`, `flushD=1` -> next `imem_addr=0x100`, `validD=0` for one cycle.
- `jumpD` with `instrD[25:0]=0x40`, `pcplus4D=0x8000_0010` -> pcF=0x8000_0100.
- `stallF=stallD=1` while `imem_ready=1` -> HOLD, `imem_req=0`, `instrD` held; on release the buffered word is delivered with no refetch.
- Redirect to 0x200 during a wait -> returned word discarded, `validD=0`, next `imem_addr=0x200`.
